multicycle_ctrl: RTL and testbench

- Multi-cycle control FSM that sequences the shared MIPS datapath: one ALU, one unified memory port, register file, PC/IR/EPC/Cause registers.
- Supports the same instruction set as the single-cycle decoder: R-type 000000, lw 100011, sw 101011, beq 000100, j 000010.
- Detects illegal opcode, overflow, memory timeout and (optionally) external interrupt, and sequences entry to the exception vector.

---
 rtl/multicycle_ctrl.sv | 237 +++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute over a shared datapath
// and vectors to the exception handler. Define CTRL_EXT_INT_EN to add the ext_int input.
module multicycle_ctrl #(
   parameter int WAIT_MAX = 16,
   parameter int CNT_W    = 5
) (
   input  logic       clk,
   input  logic       rst_n,
`ifdef CTRL_EXT_INT_EN
   input  logic       ext_int,
`endif
   input  logic [5:0] OP,
   input  logic       OF,
   input  logic       Zero,
   input  logic       mem_ready,
   output logic       PCWrite,
   output logic       PCWriteCond,
   output logic       IorD,
   output logic       MemRd,
   output logic       MemWr,
   output logic       IRWrite,
   output logic       MemtoReg,
   output logic       RegWr,
   output logic       RegDst,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOp,
   output logic [1:0] PCSource,
   output logic       EPCWrite,
   output logic       CauseWrite,
   output logic [1:0] IntCause,
   output logic       CPUInt,
   output logic [3:0] state
);

   localparam logic [5:0] OP_R   = 6'b000000;
   localparam logic [5:0] OP_LW  = 6'b100011;
   localparam logic [5:0] OP_SW  = 6'b101011;
   localparam logic [5:0] OP_BEQ = 6'b000100;
   localparam logic [5:0] OP_J   = 6'b000010;

   typedef enum logic [3:0] {
      FETCH  = 4'd0,
      DECODE = 4'd1,
      MEMADR = 4'd2,
      MEMRD  = 4'd3,
      MEMWB  = 4'd4,
      MEMWR  = 4'd5,
      EXEC   = 4'd6,
      RWB    = 4'd7,
      BRANCH = 4'd8,
      JUMP   = 4'd9,
      EXCP   = 4'd10
   } state_t;

   state_t           cur_state, next_state;
   logic [CNT_W-1:0] wait_cnt;
   logic             wait_state, timeout, ext_irq;
   logic             cause_load;
   logic [1:0]       cause_next;

   // The branch condition is resolved in the datapath (PCWriteCond & Zero).
   logic unused_zero;
   assign unused_zero = Zero;

   assign state      = cur_state;
   assign wait_state = (cur_state == FETCH) || (cur_state == MEMRD) || (cur_state == MEMWR);
   assign timeout    = wait_state && !mem_ready && (wait_cnt == CNT_W'(WAIT_MAX - 1));

`ifdef CTRL_EXT_INT_EN
   assign ext_irq = ext_int && (cur_state == FETCH) && (wait_cnt == '0);
`else
   assign ext_irq = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur_state <= FETCH;
         wait_cnt  <= '0;
         IntCause  <= 2'd0;
      end else begin
         cur_state <= next_state;
         if (next_state != cur_state)
            wait_cnt <= '0;
         else if (wait_state && !mem_ready)
            wait_cnt <= wait_cnt + CNT_W'(1);
         if (cause_load)
            IntCause <= cause_next;
      end
   end

   always_comb begin
      next_state  = cur_state;
      cause_load  = 1'b0;
      cause_next  = 2'd0;
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRd       = 1'b0;
      MemWr       = 1'b0;
      IRWrite     = 1'b0;
      MemtoReg    = 1'b0;
      RegWr       = 1'b0;
      RegDst      = 1'b0;
      ALUSrcA     = 1'b0;
      ALUSrcB     = 2'b00;
      ALUOp       = 2'b00;
      PCSource    = 2'b00;
      EPCWrite    = 1'b0;
      CauseWrite  = 1'b0;
      CPUInt      = 1'b0;

      case (cur_state)
         FETCH: begin
            ALUSrcB = 2'b01;
            if (ext_irq) begin
               next_state = EXCP;
               cause_load = 1'b1;
               cause_next = 2'd3;
            end else begin
               MemRd   = !timeout;
               IRWrite = mem_ready;
               PCWrite = mem_ready;
               if (mem_ready) begin
                  next_state = DECODE;
               end else if (timeout) begin
                  next_state = EXCP;
                  cause_load = 1'b1;
                  cause_next = 2'd2;
               end
            end
         end
         DECODE: begin
            ALUSrcB = 2'b11;
            case (OP)
               OP_LW, OP_SW: next_state = MEMADR;
               OP_R:         next_state = EXEC;
               OP_BEQ:       next_state = BRANCH;
               OP_J:         next_state = JUMP;
               default: begin
                  next_state = EXCP;
                  cause_load = 1'b1;
                  cause_next = 2'd0;
               end
            endcase
         end
         MEMADR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            if (OP == OP_SW)
               next_state = MEMWR;
            else if (OP == OP_LW)
               next_state = MEMRD;
            else
               next_state = FETCH;
         end
         MEMRD: begin
            IorD  = 1'b1;
            MemRd = !timeout;
            if (mem_ready) begin
               next_state = MEMWB;
            end else if (timeout) begin
               next_state = EXCP;
               cause_load = 1'b1;
               cause_next = 2'd2;
            end
         end
         MEMWB: begin
            RegWr      = 1'b1;
            MemtoReg   = 1'b1;
            next_state = FETCH;
         end
         MEMWR: begin
            IorD  = 1'b1;
            MemWr = !timeout;
            if (mem_ready) begin
               next_state = FETCH;
            end else if (timeout) begin
               next_state = EXCP;
               cause_load = 1'b1;
               cause_next = 2'd2;
            end
         end
         EXEC: begin
            ALUSrcA    = 1'b1;
            ALUOp      = 2'b10;
            next_state = RWB;
         end
         RWB: begin
            // An overflowing result must never reach the register file.
            RegDst = 1'b1;
            RegWr  = !OF;
            if (OF) begin
               next_state = EXCP;
               cause_load = 1'b1;
               cause_next = 2'd1;
            end else begin
               next_state = FETCH;
            end
         end
         BRANCH: begin
            ALUSrcA     = 1'b1;
            ALUOp       = 2'b01;
            PCWriteCond = 1'b1;
            PCSource    = 2'b01;
            next_state  = FETCH;
         end
         JUMP: begin
            PCWrite    = 1'b1;
            PCSource   = 2'b10;
            next_state = FETCH;
         end
         EXCP: begin
            CPUInt     = 1'b1;
            EPCWrite   = 1'b1;
            CauseWrite = 1'b1;
            PCWrite    = 1'b1;
            PCSource   = 2'b11;
            next_state = FETCH;
         end
         default: next_state = FETCH;
      endcase

      // Reset kills every architectural write immediately, even mid-instruction.
      if (!rst_n) begin
         PCWrite     = 1'b0;
         PCWriteCond = 1'b0;
         MemWr       = 1'b0;
         RegWr       = 1'b0;
         IRWrite     = 1'b0;
         EPCWrite    = 1'b0;
         CauseWrite  = 1'b0;
         CPUInt      = 1'b0;
      end
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: a table of per-cycle vectors from reset,
// then hand-written timeout, ready-vs-timeout, mid-instruction reset and interrupt cases.
module tb_multicycle_ctrl;

   localparam logic [5:0] OP_R   = 6'b000000;
   localparam logic [5:0] OP_LW  = 6'b100011;
   localparam logic [5:0] OP_SW  = 6'b101011;
   localparam logic [5:0] OP_BEQ = 6'b000100;
   localparam logic [5:0] OP_J   = 6'b000010;
   localparam logic [5:0] OP_BAD = 6'b111111;

   logic       clk, rst_n;
   logic [5:0] OP;
   logic       OF, Zero, mem_ready;
   logic       PCWrite, PCWriteCond, IorD, MemRd, MemWr, IRWrite, MemtoReg, RegWr, RegDst, ALUSrcA;
   logic [1:0] ALUSrcB, ALUOp, PCSource, IntCause;
   logic       EPCWrite, CauseWrite, CPUInt;
   logic [3:0] state;
`ifdef CTRL_EXT_INT_EN
   logic       ext_int;
`endif

   int total = 0;
   int bad   = 0;

   multicycle_ctrl #(.WAIT_MAX(16), .CNT_W(5)) dut (
      .clk(clk), .rst_n(rst_n),
`ifdef CTRL_EXT_INT_EN
      .ext_int(ext_int),
`endif
      .OP(OP), .OF(OF), .Zero(Zero), .mem_ready(mem_ready),
      .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRd(MemRd), .MemWr(MemWr),
      .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegWr(RegWr), .RegDst(RegDst), .ALUSrcA(ALUSrcA),
      .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource), .EPCWrite(EPCWrite),
      .CauseWrite(CauseWrite), .IntCause(IntCause), .CPUInt(CPUInt), .state(state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // strb = {PCWrite,PCWriteCond,IorD,MemRd,MemWr,IRWrite,MemtoReg,RegWr,RegDst,ALUSrcA}
   // exc  = {EPCWrite,CauseWrite,CPUInt}
   typedef struct packed {
      logic [5:0] op;
      logic       ovf;
      logic       zero;
      logic       rdy;
      logic [3:0] st;
      logic [9:0] strb;
      logic [1:0] srcb;
      logic [1:0] aluop;
      logic [1:0] pcsrc;
      logic [2:0] exc;
      logic [1:0] cause;
   } vec_t;

   vec_t vecs[$];

   task automatic applyStimulus(input logic [5:0] op, input logic ovf, input logic zero, input logic rdy);
      OP        = op;
      OF        = ovf;
      Zero      = zero;
      mem_ready = rdy;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [20:0] packed_outs();
      return {PCWrite, PCWriteCond, IorD, MemRd, MemWr, IRWrite, MemtoReg, RegWr, RegDst, ALUSrcA,
              ALUSrcB, ALUOp, PCSource, EPCWrite, CauseWrite, CPUInt, IntCause};
   endfunction

   initial begin
      int n;
      // add, no overflow
      vecs.push_back('{OP_R,   0,0,1, 4'd0,  10'b1001010000, 2'b01,2'b00,2'b00,3'b000,2'd0});
      vecs.push_back('{OP_R,   0,0,1, 4'd1,  10'b0000000000, 2'b11,2'b00,2'b00,3'b000,2'd0});
      vecs.push_back('{OP_R,   0,0,1, 4'd6,  10'b0000000001, 2'b00,2'b10,2'b00,3'b000,2'd0});
      vecs.push_back('{OP_R,   0,0,1, 4'd7,  10'b0000000110, 2'b00,2'b00,2'b00,3'b000,2'd0});
      // lw, one fetch stall then three MEMRD stalls
      vecs.push_back('{OP_LW,  0,0,0, 4'd0,  10'b0001000000, 2'b01,2'b00,2'b00,3'b000,2'd0});
      vecs.push_back('{OP_LW,  0,0,1, 4'd0,  10'b1001010000, 2'b01,2'b00,2'b00,3'b000,2'd0});
      vecs.push_back('{OP_LW,  0,0,1, 4'd1,  10'b0000000000, 2'b11,2'b00,2'b00,3'b000,2'd0});
      vecs.push_back('{OP_LW,  0,0,1, 4'd2,  10'b0000000001, 2'b10,2'b00,2'b00,3'b000,2'd0});
      vecs.push_back('{OP_LW,  0,0,0, 4'd3,  10'b0011000000, 2'b00,2'b00,2'b00,3'b000,2'd0});
      vecs.push_back('{OP_LW,  0,0,0, 4'd3,  10'b0011000000, 2'b00,2'b00,2'b00,3'b000,2'd0});
      vecs.push_back('{OP_LW,  0,0,0, 4'd3,  10'b0011000000, 2'b00,2'b00,2'b00,3'b000,2'd0});
      vecs.push_back('{OP_LW,  0,0,1, 4'd3,  10'b0011000000, 2'b00,2'b00,2'b00,3'b000,2'd0});
      vecs.push_back('{OP_LW,  0,0,1, 4'd4,  10'b0000001100, 2'b00,2'b00,2'b00,3'b000,2'd0});
      // sw, zero wait
      vecs.push_back('{OP_SW,  0,0,1, 4'd0,  10'b1001010000, 2'b01,2'b00,2'b00,3'b000,2'd0});
      vecs.push_back('{OP_SW,  0,0,1, 4'd1,  10'b0000000000, 2'b11,2'b00,2'b00,3'b000,2'd0});
      vecs.push_back('{OP_SW,  0,0,1, 4'd2,  10'b0000000001, 2'b10,2'b00,2'b00,3'b000,2'd0});
      vecs.push_back('{OP_SW,  0,0,1, 4'd5,  10'b0010100000, 2'b00,2'b00,2'b00,3'b000,2'd0});
      // beq taken, then not taken: controller outputs identical
      vecs.push_back('{OP_BEQ, 0,1,1, 4'd0,  10'b1001010000, 2'b01,2'b00,2'b00,3'b000,2'd0});
      vecs.push_back('{OP_BEQ, 0,1,1, 4'd1,  10'b0000000000, 2'b11,2'b00,2'b00,3'b000,2'd0});
      vecs.push_back('{OP_BEQ, 0,1,1, 4'd8,  10'b0100000001, 2'b00,2'b01,2'b01,3'b000,2'd0});
      vecs.push_back('{OP_BEQ, 0,0,1, 4'd0,  10'b1001010000, 2'b01,2'b00,2'b00,3'b000,2'd0});
      vecs.push_back('{OP_BEQ, 0,0,1, 4'd1,  10'b0000000000, 2'b11,2'b00,2'b00,3'b000,2'd0});
      vecs.push_back('{OP_BEQ, 0,0,1, 4'd8,  10'b0100000001, 2'b00,2'b01,2'b01,3'b000,2'd0});
      // j
      vecs.push_back('{OP_J,   0,0,1, 4'd0,  10'b1001010000, 2'b01,2'b00,2'b00,3'b000,2'd0});
      vecs.push_back('{OP_J,   0,0,1, 4'd1,  10'b0000000000, 2'b11,2'b00,2'b00,3'b000,2'd0});
      vecs.push_back('{OP_J,   0,0,1, 4'd9,  10'b1000000000, 2'b00,2'b00,2'b10,3'b000,2'd0});
      // R-type with overflow -> cause 1
      vecs.push_back('{OP_R,   0,0,1, 4'd0,  10'b1001010000, 2'b01,2'b00,2'b00,3'b000,2'd0});
      vecs.push_back('{OP_R,   0,0,1, 4'd1,  10'b0000000000, 2'b11,2'b00,2'b00,3'b000,2'd0});
      vecs.push_back('{OP_R,   0,0,1, 4'd6,  10'b0000000001, 2'b00,2'b10,2'b00,3'b000,2'd0});
      vecs.push_back('{OP_R,   1,0,1, 4'd7,  10'b0000000010, 2'b00,2'b00,2'b00,3'b000,2'd0});
      vecs.push_back('{OP_R,   0,0,1, 4'd10, 10'b1000000000, 2'b00,2'b00,2'b11,3'b111,2'd1});
      // illegal opcode -> cause 0
      vecs.push_back('{OP_BAD, 0,0,1, 4'd0,  10'b1001010000, 2'b01,2'b00,2'b00,3'b000,2'd1});
      vecs.push_back('{OP_BAD, 0,0,1, 4'd1,  10'b0000000000, 2'b11,2'b00,2'b00,3'b000,2'd1});
      vecs.push_back('{OP_BAD, 0,0,1, 4'd10, 10'b1000000000, 2'b00,2'b00,2'b11,3'b111,2'd0});
      vecs.push_back('{OP_R,   0,0,0, 4'd0,  10'b0001000000, 2'b01,2'b00,2'b00,3'b000,2'd0});

`ifdef CTRL_EXT_INT_EN
      ext_int = 1'b0;
`endif
      rst_n = 1'b0;
      applyStimulus(OP_R, 1'b0, 1'b0, 1'b1);
      repeat (2) @(negedge clk);
      checkOutput("reset_state", 32'(state), 32'd0);
      checkOutput("reset_strobes", {26'd0, PCWrite, IRWrite, EPCWrite, CauseWrite, CPUInt, RegWr},
                  32'd0);
      checkOutput("reset_cause", 32'(IntCause), 32'd0);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].op, vecs[i].ovf, vecs[i].zero, vecs[i].rdy);
         #1;
         checkOutput($sformatf("vec%0d_state", i), 32'(state), 32'(vecs[i].st));
         checkOutput($sformatf("vec%0d_outs", i), 32'(packed_outs()),
                     32'({vecs[i].strb, vecs[i].srcb, vecs[i].aluop, vecs[i].pcsrc,
                          vecs[i].exc, vecs[i].cause}));
         @(negedge clk);
      end

      // sw with memory stuck: 16 MEMWR cycles, then EXCP with cause 2
      applyStimulus(OP_SW, 1'b0, 1'b0, 1'b1);
      repeat (3) @(negedge clk);
      applyStimulus(OP_SW, 1'b0, 1'b0, 1'b0);
      #1;
      checkOutput("to_memwr_first", {30'd0, MemWr, IorD}, 32'd3);
      n = 0;
      for (int i = 0; i < 40 && state == 4'd5; i++) begin
         if (n == 15) checkOutput("to_memwr_drop", 32'(MemWr), 32'd0);
         n++;
         @(negedge clk);
         #1;
      end
      checkOutput("to_cycles", 32'(n), 32'd16);
      checkOutput("to_state", 32'(state), 32'd10);
      checkOutput("to_cause", 32'(IntCause), 32'd2);
      checkOutput("to_cpuint", 32'(CPUInt), 32'd1);
      @(negedge clk);
      #1;
      checkOutput("to_back_fetch", 32'(state), 32'd0);

      // lw where mem_ready arrives on the last allowed wait cycle
      applyStimulus(OP_LW, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      applyStimulus(OP_LW, 1'b0, 1'b0, 1'b0);
      repeat (15) @(negedge clk);
      applyStimulus(OP_LW, 1'b0, 1'b0, 1'b1);
      #1;
      checkOutput("rw_memrd_held", {30'd0, state == 4'd3, MemRd}, 32'd3);
      @(negedge clk);
      #1;
      checkOutput("rw_memwb", 32'(state), 32'd4);
      checkOutput("rw_cause_held", 32'(IntCause), 32'd2);
      @(negedge clk);

      // reset pulsed while a store is waiting in MEMWR
      applyStimulus(OP_SW, 1'b0, 1'b0, 1'b1);
      repeat (3) @(negedge clk);
      applyStimulus(OP_SW, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      #3;
      checkOutput("rst_pre_memwr", {28'd0, state}, 32'd5);
      mem_ready = 1'b1;
      rst_n     = 1'b0;
      #1;
      checkOutput("rst_memwr_drop", 32'(MemWr), 32'd0);
      checkOutput("rst_state", 32'(state), 32'd0);
      checkOutput("rst_cause", 32'(IntCause), 32'd0);
      checkOutput("rst_gated", {30'd0, PCWrite, IRWrite}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checkOutput("rst_release_fetch", {27'd0, state, MemRd}, 32'd1);
      checkOutput("rst_release_irwrite", 32'(IRWrite), 32'd1);
      @(negedge clk);
      #1;
      checkOutput("rst_restart_decode", 32'(state), 32'd1);

`ifdef CTRL_EXT_INT_EN
      // finish the store, then raise ext_int on the first FETCH cycle
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      #1;
      checkOutput("ei_fetch", 32'(state), 32'd0);
      ext_int = 1'b1;
      #1;
      checkOutput("ei_memrd_off", {30'd0, MemRd, IRWrite}, 32'd0);
      @(negedge clk);
      ext_int = 1'b0;
      #1;
      checkOutput("ei_excp", 32'(state), 32'd10);
      checkOutput("ei_cause", 32'(IntCause), 32'd3);
      @(negedge clk);
      #1;
      checkOutput("ei_back_fetch", 32'(state), 32'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
